veerwolf_wb_initiator: RTL and testbench



---
 rtl/veerwolf_wb_initiator.sv | 123 ++++++++++++
 tb/tb_veerwolf_wb_initiator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/veerwolf_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one bus cycle per accepted
// command, with read data and status returned on a response stream.
//
// state | meaning
// IDLE  | ready for a command
// BUS   | Wishbone cycle in flight, waiting for ack/err/timeout
// RSP   | response presented, waiting for i_rsp_ready
module veerwolf_wb_initiator #(
    parameter int AW      = 6,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [AW-1:0] i_cmd_adr,
    input  logic [31:0]   i_cmd_dat,
    input  logic [3:0]    i_cmd_sel,
    input  logic          i_cmd_we,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_dat,
    output logic          o_rsp_err,
    output logic          o_rsp_to,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    input  logic          i_wb_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    localparam bit          TO_EN     = (TIMEOUT != 0);
    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];

    logic [1:0]      state;
    logic [TO_W-1:0] cnt;

    assign o_cmd_ready = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_sel    <= '0;
            o_wb_we     <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b0;
            o_rsp_to    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        o_wb_adr <= i_cmd_adr;
                        o_wb_dat <= i_cmd_dat;
                        o_wb_sel <= i_cmd_sel;
                        o_wb_we  <= i_cmd_we;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        cnt      <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // cyc must drop on the terminating edge, or a responder
                    // acking on cyc & !ack would complete the cycle twice
                    if (i_wb_err) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_dat   <= '0;
                        o_rsp_err   <= 1'b1;
                        o_rsp_to    <= 1'b0;
                        state       <= RSP;
                    end else if (i_wb_ack) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_dat   <= o_wb_we ? 32'h0 : i_wb_rdt;
                        o_rsp_err   <= 1'b0;
                        o_rsp_to    <= 1'b0;
                        state       <= RSP;
                    end else if (TO_EN && (cnt == TO_LAST)) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_dat   <= '0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_to    <= 1'b1;
                        state       <= RSP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_dat   <= '0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_to    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_veerwolf_wb_initiator.sv
// Directed bench for veerwolf_wb_initiator with a behavioural Wishbone
// responder whose ack delay and failure mode are set per step.
module tb_veerwolf_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        cmd_we;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err, rsp_to;
    logic [5:0]  wb_adr;
    logic [31:0] wb_dat, wb_rdt;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;

    int checks = 0;
    int passes = 0;

    // responder: mode 0 = ack, 1 = never answer, 2 = ack and err together
    int          resp_mode = 0;
    int          resp_delay = 0;
    int          wcnt = 0;
    logic [31:0] mem [64];
    int          cyc_hi = 0;
    int          ack_cnt = 0;
    logic        stab_bad = 1'b0;
    logic [5:0]  exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic        exp_we;
    logic [31:0] held_dat;

    always #5 clk = ~clk;

    veerwolf_wb_initiator #(.AW(6), .TIMEOUT(8), .TO_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel), .i_cmd_we(cmd_we),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_dat(rsp_dat), .o_rsp_err(rsp_err), .o_rsp_to(rsp_to),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .i_wb_err(wb_err)
    );

    assign wb_ack = wb_cyc && wb_stb && (resp_mode != 1) && (wcnt == resp_delay);
    assign wb_err = wb_cyc && wb_stb && (resp_mode == 2) && (wcnt == resp_delay);
    assign wb_rdt = mem[wb_adr];

    always @(posedge clk) begin
        wcnt <= (wb_cyc && wb_stb) ? wcnt + 1 : 0;
        if (wb_cyc) cyc_hi <= cyc_hi + 1;
        if (wb_cyc && (wb_adr !== exp_adr || wb_sel !== exp_sel ||
                       wb_we !== exp_we || (exp_we && wb_dat !== exp_dat)))
            stab_bad <= 1'b1;
        if (wb_ack && wb_cyc) begin
            ack_cnt <= ack_cnt + 1;
            if (wb_we && !wb_err)
                for (int b = 0; b < 4; b++)
                    if (wb_sel[b]) mem[wb_adr][b*8 +: 8] <= wb_dat[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w);
        @(negedge clk);
        cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_we = w; cmd_valid = 1'b1;
        exp_adr = a; exp_dat = d; exp_sel = s; exp_we = w;
        cyc_hi = 0; ack_cnt = 0; stab_bad = 1'b0;
        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        check("rsp_arrives", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_released", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_we = 1'b0;
        exp_adr = '0; exp_sel = '0; exp_dat = '0; exp_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_wb_adr", {26'b0, wb_adr}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rst_n = 1'b1;

        // single-cycle write
        resp_mode = 0; resp_delay = 0;
        send(6'h10, 32'hA5A5_1234, 4'hF, 1'b1);
        wait_rsp();
        check("wr_err", {31'b0, rsp_err}, 32'd0);
        check("wr_to", {31'b0, rsp_to}, 32'd0);
        check("wr_dat", rsp_dat, 32'd0);
        check("wr_cyc_hi", cyc_hi, 32'd1);
        check("wr_acks", ack_cnt, 32'd1);
        check("wr_mem", mem[16], 32'hA5A5_1234);
        take_rsp();

        // preload 0x3C, then read it back through a 5-cycle-delay responder
        send(6'h3C, 32'h02FA_F080, 4'hF, 1'b1);
        wait_rsp();
        take_rsp();
        resp_delay = 5;
        send(6'h3C, 32'h0, 4'h5, 1'b0);
        wait_rsp();
        check("rd_dat", rsp_dat, 32'h02FA_F080);
        check("rd_cyc_hi", cyc_hi, 32'd6);
        check("rd_stable", {31'b0, stab_bad}, 32'd0);
        check("rd_err", {31'b0, rsp_err}, 32'd0);
        take_rsp();

        // dead responder -> timeout after 8 cycles
        resp_mode = 1;
        send(6'h08, 32'h0, 4'hF, 1'b0);
        wait_rsp();
        check("to_flag", {31'b0, rsp_to}, 32'd1);
        check("to_cyc_hi", cyc_hi, 32'd8);
        check("to_dat", rsp_dat, 32'd0);
        check("to_err", {31'b0, rsp_err}, 32'd0);
        take_rsp();
        resp_mode = 0; resp_delay = 0;
        send(6'h10, 32'h0, 4'hF, 1'b0);
        wait_rsp();
        check("after_to_dat", rsp_dat, 32'hA5A5_1234);
        check("after_to_to", {31'b0, rsp_to}, 32'd0);
        take_rsp();

        // ack and err together: err wins
        resp_mode = 2; resp_delay = 1;
        send(6'h3C, 32'h0, 4'hF, 1'b0);
        wait_rsp();
        check("ae_err", {31'b0, rsp_err}, 32'd1);
        check("ae_dat", rsp_dat, 32'd0);
        check("ae_to", {31'b0, rsp_to}, 32'd0);
        take_rsp();

        // held response blocks the next command
        resp_mode = 0; resp_delay = 0;
        send(6'h10, 32'h0, 4'hF, 1'b0);
        wait_rsp();
        held_dat = rsp_dat;
        check("bb_first_dat", held_dat, 32'hA5A5_1234);
        cmd_adr = 6'h20; cmd_dat = 32'h0000_0055; cmd_sel = 4'h1; cmd_we = 1'b1;
        exp_adr = 6'h20; exp_dat = 32'h0000_0055; exp_sel = 4'h1; exp_we = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bb_ready_low", {31'b0, cmd_ready}, 32'd0);
            check("bb_rsp_held", rsp_dat, held_dat);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bb_cyc_not_yet", {31'b0, wb_cyc}, 32'd0);
        check("bb_ready_back", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bb_second_cyc", {31'b0, wb_cyc}, 32'd1);
        wait_rsp();
        take_rsp();
        check("bb_second_mem", mem[32], 32'h0000_0055);

        // reset in the middle of a bus cycle
        resp_mode = 1;
        send(6'h04, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("mid_cyc_before", {31'b0, wb_cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_cyc_async", {31'b0, wb_cyc}, 32'd0);
        check("mid_stb_async", {31'b0, wb_stb}, 32'd0);
        check("mid_rsp_async", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_mode = 0;
        repeat (12) @(negedge clk);
        check("mid_no_stale", {31'b0, rsp_valid}, 32'd0);
        check("mid_ready", {31'b0, cmd_ready}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
